mod_addsub_vec: RTL and testbench

- Multi-lane, pipelined modular adder/subtractor. Each transaction computes (a+b) mod q or (a−b) mod q on LANES independent K-bit operand pairs sharing one modulus q.
- Successor to the single-lane, subtract-only, free-running modular subtractor.
- Adds an operation select, valid/ready flow control with backpressure, a sideband tag, and lane-width generalisation.
- Sits between NTT butterfly/coefficient buffers and downstream ring-arithmetic consumers.

---
 rtl/mod_addsub_vec.sv | 125 ++++++++++++
 tb/tb_mod_addsub_vec.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_addsub_vec.sv
// mod_addsub_vec: LANES-wide, two-stage pipelined modular adder/subtractor with valid/ready flow control.
// Define MODADDSUB_RANGE_CHECK_EN to add the per-lane operand range flag port out_err.
module mod_addsub_vec #(
  parameter int K     = 54,
  parameter int LANES = 4,
  parameter int TAGW  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_op,
  input  logic [TAGW-1:0]      in_tag,
  input  logic [K-1:0]         q,
  input  logic [LANES*K-1:0]   ina,
  input  logic [LANES*K-1:0]   inb,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TAGW-1:0]      out_tag,
  output logic [LANES*K-1:0]   out_data
`ifdef MODADDSUB_RANGE_CHECK_EN
  ,
  output logic [LANES-1:0]     out_err
`endif
);

  logic                    v1;
  logic                    op1;
  logic [K-1:0]            q1;
  logic [TAGW-1:0]         tag1;
  logic [LANES-1:0][K:0]   raw1;

  logic                    adv1;
  logic                    adv2;
  logic                    in_xfer;
  logic [K:0]              q_ext;
  logic [LANES-1:0][K:0]   raw_next;
  logic [LANES-1:0][K:0]   minus_q;
  logic [LANES-1:0][K:0]   plus_q;
  logic [LANES*K-1:0]      res_next;

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !v1 || adv2;
  assign in_ready = adv1;
  assign in_xfer  = in_valid && adv1;
  assign q_ext    = {1'b0, q1};

  // One extra bit per lane holds the add carry or the subtract borrow.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    raw_next = '0;
    for (int i = 0; i < LANES; i++) begin
      if (in_op) raw_next[i] = {1'b0, ina[i*K +: K]} - {1'b0, inb[i*K +: K]};
      else       raw_next[i] = {1'b0, ina[i*K +: K]} + {1'b0, inb[i*K +: K]};
    end
  end

  always_comb begin
    minus_q  = '0;
    plus_q   = '0;
    res_next = '0;
    for (int i = 0; i < LANES; i++) begin
      minus_q[i] = raw1[i] - q_ext;
      plus_q[i]  = raw1[i] + q_ext;
      if (op1) res_next[i*K +: K] = raw1[i][K] ? plus_q[i][K-1:0] : raw1[i][K-1:0];
      else     res_next[i*K +: K] = (raw1[i] >= q_ext) ? minus_q[i][K-1:0] : raw1[i][K-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers use non-blocking assignments so all stages update from pre-edge values.
    if (!rst_n) begin
      v1   <= 1'b0;
      op1  <= 1'b0;
      q1   <= '0;
      tag1 <= '0;
      raw1 <= '0;
    end else if (adv1) begin
      v1 <= in_xfer;
      if (in_xfer) begin
        op1  <= in_op;
        q1   <= q;
        tag1 <= in_tag;
        raw1 <= raw_next;
      end
    end
  end

  // Output holds while stalled; tag and result always move together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_data  <= '0;
    end else if (adv2) begin
      out_valid <= v1;
      if (v1) begin
        out_tag  <= tag1;
        out_data <= res_next;
      end
    end
  end

`ifdef MODADDSUB_RANGE_CHECK_EN
  logic [LANES-1:0] err_next;
  logic [LANES-1:0] err1;

  always_comb begin
    err_next = '0;
    for (int i = 0; i < LANES; i++)
      err_next[i] = (ina[i*K +: K] >= q) || (inb[i*K +: K] >= q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err1    <= '0;
      out_err <= '0;
    end else begin
      if (in_xfer)   err1    <= err_next;
      if (adv2 && v1) out_err <= err1;
    end
  end
`endif

endmodule

// File: tb/tb_mod_addsub_vec.sv
// Self-checking bench for mod_addsub_vec: directed vectors, backpressure, full-rate mixed stream, mid-flight reset.
// Also checks out_err when built with MODADDSUB_RANGE_CHECK_EN.
module tb_mod_addsub_vec;
  localparam int K  = 54;
  localparam int L  = 4;
  localparam int TW = 8;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic            in_op;
  logic [TW-1:0]   in_tag;
  logic [K-1:0]    q;
  logic [L*K-1:0]  ina;
  logic [L*K-1:0]  inb;
  logic            out_valid;
  logic            out_ready;
  logic [TW-1:0]   out_tag;
  logic [L*K-1:0]  out_data;
`ifdef MODADDSUB_RANGE_CHECK_EN
  logic [L-1:0]    out_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  mod_addsub_vec #(.K(K), .LANES(L), .TAGW(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .q         (q),
    .ina       (ina),
    .inb       (inb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tag   (out_tag),
    .out_data  (out_data)
`ifdef MODADDSUB_RANGE_CHECK_EN
    ,
    .out_err   (out_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [L*K-1:0] pack(input logic [K-1:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  // Reference residue computed with wide integer arithmetic and the % operator.
  function automatic logic [K-1:0] mod_ref(input logic op, input logic [K-1:0] m, a, b);
    logic [63:0] r;
    if (op) r = ({10'd0, a} + {10'd0, m} - {10'd0, b}) % {10'd0, m};
    else    r = ({10'd0, a} + {10'd0, b}) % {10'd0, m};
    return r[K-1:0];
  endfunction

  task automatic drive(input logic op, input logic [K-1:0] m, input logic [L*K-1:0] a, b,
                       input logic [TW-1:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    q        = m;
    ina      = a;
    inb      = b;
    in_tag   = tag;
  endtask

  task automatic single(input string nm, input logic op, input logic [K-1:0] m,
                        input logic [L*K-1:0] a, b, input logic [TW-1:0] tag,
                        input logic [L*K-1:0] exp);
    out_ready = 1'b1;
    drive(op, m, a, b, tag);
    check({nm, "_in_ready"}, in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    check({nm, "_valid"}, out_valid, 1'b1);
    check({nm, "_data"}, out_data, exp);
    check({nm, "_tag"}, out_tag, tag);
  endtask

  // Streams n transactions with out_ready low during cycles st_lo..st_hi; scoreboard checks order and content.
  task automatic run_stream(input string nm, input int n, input bit mixed, input int st_lo, input int st_hi,
                            output int cycles, output bit blocked);
    logic [L*K+TW-1:0] expq[$];
    logic [L*K+TW-1:0] e;
    logic [L*K-1:0]    a, b, x, prev_d;
    logic [TW-1:0]     prev_t;
    logic [K-1:0]      m, ai, bi;
    logic              op;
    int                sent, got, c;
    bit                prev_stall;
    sent = 0; got = 0; prev_stall = 0; blocked = 0;
    prev_d = '0; prev_t = '0;
    for (c = 0; c < 200 && got < n; c++) begin
      out_ready = !(c >= st_lo && c <= st_hi);
      if (sent < n) begin
        op = mixed ? sent[0] : 1'b0;
        m  = (mixed && !sent[0]) ? K'(17) : K'(97);
        for (int i = 0; i < L; i++) begin
          ai = K'((sent * 13 + i * 7 + 1) % int'(m));
          bi = K'((sent * 29 + i * 11 + 3) % int'(m));
          a[i*K +: K] = ai;
          b[i*K +: K] = bi;
          x[i*K +: K] = mod_ref(op, m, ai, bi);
        end
        drive(op, m, a, b, TW'(sent + 1));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prev_stall) begin
        check({nm, "_stall_valid"}, out_valid, 1'b1);
        check({nm, "_stall_data"}, out_data, prev_d);
        check({nm, "_stall_tag"}, out_tag, prev_t);
      end
      if (in_valid && !in_ready) blocked = 1;
      if (in_valid && in_ready) begin
        expq.push_back({TW'(sent + 1), x});
        sent++;
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check({nm, "_unexpected_output"}, 1'b1, 1'b0);
        end else begin
          e = expq.pop_front();
          check({nm, "_tag"}, out_tag, e[L*K +: TW]);
          check({nm, "_data"}, out_data, e[L*K-1:0]);
        end
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      prev_t     = out_tag;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycles    = c;
    check({nm, "_count"}, got, n);
  endtask

  logic [K-1:0] qm;
  int           cyc;
  bit           blk;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = 1'b0; in_tag = '0;
    q = '0; ina = '0; inb = '0; out_ready = 1'b1;
    qm = '1;

    // Reset and idle
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_tag", out_tag, '0);
`ifdef MODADDSUB_RANGE_CHECK_EN
    check("rst_out_err", out_err, '0);
`endif
    #5 rst_n = 1'b1;
    step();
    check("idle_in_ready", in_ready, 1'b1);

    // Directed vectors, expected values worked out by hand
    single("add17", 1'b0, K'(17), pack(3, 16, 8, 0), pack(5, 1, 9, 0), 8'h2A, pack(8, 0, 0, 0));
`ifdef MODADDSUB_RANGE_CHECK_EN
    check("add17_err", out_err, '0);
`endif
    single("sub17", 1'b1, K'(17), pack(3, 16, 8, 5), pack(5, 1, 8, 0), 8'h11, pack(15, 15, 0, 5));
    single("sub_maxq", 1'b1, qm, pack(0, qm - 1, 5, 7), pack(qm - 1, qm - 1, 0, 7), 8'h33,
           pack(1, 0, 5, 0));
    single("add_maxq", 1'b0, qm, pack(qm - 1, 1, qm - 2, 0), pack(qm - 1, qm - 1, 1, 0), 8'h44,
           pack(qm - 2, 0, qm - 1, 0));
    step();

    // Backpressure: out_ready low for cycles 3..7
    run_stream("bp", 6, 1'b0, 3, 7, cyc, blk);
    check("bp_in_ready_dropped", blk, 1'b1);
    step();

    // Full-rate mixed stream: one result per cycle after the 2-cycle latency
    run_stream("fr", 10, 1'b1, -1, -1, cyc, blk);
    check("fr_cycles", cyc, 10 + 2);
    check("fr_never_blocked", blk, 1'b0);
    step();

    // Reset with two transactions in flight
    out_ready = 1'b0;
    drive(1'b0, K'(17), pack(1, 2, 3, 4), pack(1, 1, 1, 1), 8'h55);
    step();
    drive(1'b1, K'(97), pack(9, 9, 9, 9), pack(1, 2, 3, 4), 8'h66);
    step();
    in_valid = 1'b0;
    check("mid_inflight_valid", out_valid, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_data", out_data, '0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_no_stale", out_valid, 1'b0);
    end

`ifdef MODADDSUB_RANGE_CHECK_EN
    single("range", 1'b0, K'(17), pack(17, 3, 0, 0), pack(0, 0, 0, 0), 8'h77, pack(0, 3, 0, 0));
    check("range_err", out_err, 4'b0001);
`endif

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end

endmodule
